// File: rtl/tinyfpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tinyfpga_pkg
//  Brief    : Shared sizes, select encoding, BEL config layout and the
//             source-select helper for the tiny FPGA cluster.
//  Revision : 1.0  initial release
// ============================================================================
package tinyfpga_pkg;

   localparam int BELS                = 4;
   localparam int BEL_INPUT_WIDTH     = 5;
   localparam int CLUSTER_INPUT_WIDTH = 5;
   localparam int LUT_BITS            = 32;
   localparam int SEL_W               = 4;
   localparam int BEL_CFG_BITS        = 53;
   localparam int CFG_BITS            = 212;

   // Sources visible to every LUT input: fabric inputs then BEL outputs
   localparam int NUM_SRC = CLUSTER_INPUT_WIDTH + BELS;

   // Select encoding
   localparam int SEL_FIN0 = 0;
   localparam int SEL_BEL0 = 5;
   localparam int SEL_ZERO = 15;

   typedef logic [SEL_W-1:0] sel_t;

   // One BEL's config slice, LSB first: truth table, ff_en, sel0..sel4
   typedef struct packed {
      sel_t [BEL_INPUT_WIDTH-1:0] sel;
      logic                       ff_en;
      logic [LUT_BITS-1:0]        truth;
   } bel_cfg_t;

   // Select one source bit; codes beyond the last source read as 0
   function automatic logic sel_src(input logic [NUM_SRC-1:0] src, input sel_t sel);
      logic r;
      r = 1'b0;
      for (int j = 0; j < NUM_SRC; j++) begin
         if (sel == sel_t'(j)) r = src[j];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyfpga_bel.sv
`default_nettype none
// ============================================================================
//  Module   : tinyfpga_bel
//  Brief    : One basic element: five source muxes, a 5-input LUT and an
//             optional output register.
//  Revision : 1.0  initial release
// ============================================================================
module tinyfpga_bel
   import tinyfpga_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               prog_en_i,
   input  bel_cfg_t           cfg_i,
   input  logic [NUM_SRC-1:0] src_i,
   output logic               out_o
);

   logic [BEL_INPUT_WIDTH-1:0] lut_idx;
   logic                       lut;
   logic                       q_q;
   logic                       q_d;

   // Each LUT input picks its own source from the shared source vector
   generate
      for (genvar i = 0; i < BEL_INPUT_WIDTH; i++) begin : g_in
         assign lut_idx[i] = sel_src(src_i, cfg_i.sel[i]);
      end
   endgenerate

   assign lut = cfg_i.truth[lut_idx];

   // Register is held at 0 while reset or while the chain is being loaded
   always_comb begin
      q_d = lut;
      if (rst || prog_en_i) q_d = 1'b0;
   end

   // Output register
   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   // Gating during programming also breaks any configured feedback loop
   // while the config bits are in motion.
   assign out_o = prog_en_i ? 1'b0 : (cfg_i.ff_en ? q_q : lut);

endmodule
`default_nettype wire

// File: rtl/riceshelley_tiny_fpga.sv
`default_nettype none
// ============================================================================
//  Module   : riceshelley_tiny_fpga
//  Brief    : Four-BEL programmable cluster behind an 8-in/8-out pin wrapper,
//             configured through a 212-bit serial scan chain.
//  Revision : 1.0  initial release
// ============================================================================
module riceshelley_tiny_fpga
   import tinyfpga_pkg::*;
(
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   logic                           clk;
   logic                           prog_en;
   logic                           prog_in;
   logic                           rst;
   logic [CLUSTER_INPUT_WIDTH-1:0] fin;
   logic [CFG_BITS-1:0]            cfg_q;
   logic [CFG_BITS-1:0]            cfg_d;
   logic [BELS-1:0]                bel_out;
   logic [NUM_SRC-1:0]             src;
   logic                           prog_out;

   // Pin 1 is reset in run mode and serial data in programming mode
   assign clk     = io_in[0];
   assign prog_en = io_in[2];
   assign prog_in = io_in[1];
   assign rst     = io_in[1] & ~io_in[2];
   assign fin     = io_in[7:3];

   // Chain shifts only while programming; config is deliberately not reset
   always_comb begin
      cfg_d = cfg_q;
      if (prog_en) cfg_d = {cfg_q[CFG_BITS-2:0], prog_in};
   end

   // Config scan-chain register
   always_ff @(posedge clk) begin
      cfg_q <= cfg_d;
   end

   assign prog_out = cfg_q[CFG_BITS-1];

   // Source order matches the select encoding: fin[0..4], then bel_out[0..3]
   assign src = {bel_out, fin};

   generate
      for (genvar k = 0; k < BELS; k++) begin : g_bel
         tinyfpga_bel u_bel (
            .clk       (clk),
            .rst       (rst),
            .prog_en_i (prog_en),
            .cfg_i     (cfg_q[k*BEL_CFG_BITS +: BEL_CFG_BITS]),
            .src_i     (src),
            .out_o     (bel_out[k])
         );
      end
   endgenerate

   assign io_out = {1'b0, prog_out, 2'b00, bel_out};

endmodule
`default_nettype wire

// File: tb/tb_riceshelley_tiny_fpga.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riceshelley_tiny_fpga
//  Brief    : Directed self-checking bench for the tiny FPGA cluster.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riceshelley_tiny_fpga;

   logic       clk;
   logic       pin1;
   logic       prog_en;
   logic [4:0] fin;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int errors;
   int checks;

   assign io_in = {fin, prog_en, pin1, clk};

   riceshelley_tiny_fpga dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] fin;
      logic       out0;
      logic       out3;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Independent packing of one BEL slice: {sel4..sel0, ff_en, table}
   function automatic logic [52:0] belc(input logic [31:0] t, input logic ff,
                                        input logic [3:0] s0, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [3:0] s3,
                                        input logic [3:0] s4);
      return {s4, s3, s2, s1, s0, ff, t};
   endfunction

   task automatic send_bit(input logic b);
      pin1 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [211:0] pat;
   logic [211:0] cfga;
   logic         t;

   initial begin
      errors  = 0;
      checks  = 0;
      pin1    = 1'b0;
      prog_en = 1'b1;
      fin     = 5'd0;

      // BEL0 AND(fin0,fin1); BEL1 toggle; BEL2 buffer of BEL1; BEL3 XOR(fin2..4)
      cfga = {belc(32'h96, 1'b0, 4'd2, 4'd3, 4'd4, 4'd15, 4'd15),
              belc(32'h02, 1'b0, 4'd6, 4'd15, 4'd15, 4'd15, 4'd15),
              belc(32'h01, 1'b1, 4'd6, 4'd15, 4'd15, 4'd15, 4'd15),
              belc(32'h08, 1'b0, 4'd0, 4'd1, 4'd15, 4'd15, 4'd15)};

      vecs[0] = '{5'b00011, 1'b1, 1'b0};
      vecs[1] = '{5'b00001, 1'b0, 1'b0};
      vecs[2] = '{5'b00010, 1'b0, 1'b0};
      vecs[3] = '{5'b11111, 1'b1, 1'b1};
      vecs[4] = '{5'b00100, 1'b0, 1'b1};
      vecs[5] = '{5'b01100, 1'b0, 1'b0};
      vecs[6] = '{5'b10111, 1'b1, 1'b0};
      vecs[7] = '{5'b11000, 1'b0, 1'b0};
      vecs[8] = '{5'b01000, 1'b0, 1'b1};

      for (int i = 0; i < 212; i++) pat[i] = ((i % 3) == 0) ^ ((i % 7) == 2);

      // Chain passthrough: send pat[0] first, then zeros push it out
      for (int i = 0; i < 212; i++) send_bit(pat[i]);
      chk("prog_io_out_low", {28'd0, io_out[3:0]}, 32'd0);
      for (int k = 0; k < 212; k++) begin
         chk($sformatf("chain_bit%0d", k), {31'd0, io_out[6]}, {31'd0, pat[k]});
         send_bit(1'b0);
      end
      chk("chain_flushed", {31'd0, io_out[6]}, 32'd0);

      // Load working configuration, MSB first
      for (int i = 211; i >= 0; i--) send_bit(cfga[i]);

      // Run mode with reset held for one edge
      prog_en = 1'b0;
      pin1    = 1'b1;
      tick();
      chk("rst_out1", {31'd0, io_out[1]}, 32'd0);
      chk("rst_out2", {31'd0, io_out[2]}, 32'd0);
      chk("rst_upper", {28'd0, io_out[7:4]}, 32'h4);
      pin1 = 1'b0;

      // Toggle and cross-BEL buffer
      t = 1'b0;
      for (int e = 0; e < 4; e++) begin
         tick();
         t = ~t;
         chk($sformatf("toggle_e%0d", e), {31'd0, io_out[1]}, {31'd0, t});
         chk($sformatf("xbel_e%0d", e), {31'd0, io_out[2]}, {31'd0, t});
      end

      // Combinational vectors while BEL1 keeps toggling
      for (int v = 0; v < 9; v++) begin
         fin = vecs[v].fin;
         tick();
         t = ~t;
         chk($sformatf("and_v%0d", v), {31'd0, io_out[0]}, {31'd0, vecs[v].out0});
         chk($sformatf("xor_v%0d", v), {31'd0, io_out[3]}, {31'd0, vecs[v].out3});
         chk($sformatf("upper_v%0d", v), {28'd0, io_out[7:4]}, 32'h4);
         chk($sformatf("tog_v%0d", v), {31'd0, io_out[1]}, {31'd0, t});
      end

      // Reset mid-run, then toggling resumes from 0 with config intact
      pin1 = 1'b1;
      tick();
      chk("midrst_out1", {31'd0, io_out[1]}, 32'd0);
      pin1 = 1'b0;
      tick();
      chk("resume_1", {31'd0, io_out[1]}, 32'd1);
      tick();
      chk("resume_0", {31'd0, io_out[1]}, 32'd0);
      fin = 5'b00011;
      #1;
      chk("cfg_intact_and", {31'd0, io_out[0]}, 32'd1);

      // Programming mode entry forces BEL outputs low
      prog_en = 1'b1;
      pin1    = 1'b0;
      #1;
      chk("prog_entry_bel", {28'd0, io_out[3:0]}, 32'd0);
      for (int e = 0; e < 3; e++) begin
         tick();
         chk($sformatf("prog_bel_e%0d", e), {28'd0, io_out[3:0]}, 32'd0);
         chk($sformatf("prog_unused_e%0d", e), {29'd0, io_out[7], io_out[5:4]}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/riceshelley_tiny_fpga.md
# riceshelley_tiny_fpga

Minimal single-cluster programmable logic fabric in an 8-in/8-out tiny-tapeout style pin wrapper. Four basic elements (BELs), each a 5-input LUT with an optional output register, are driven by per-input source multiplexers over the five fabric inputs and the four BEL outputs. All configuration is held in one serial scan chain that is loaded through the same pins used for reset while programming is enabled. The block is the whole chip-level design.

## Interface
- `BELS`, 4: number of BELs in the cluster.
- `BEL_INPUT_WIDTH`, 5: LUT inputs per BEL; LUT has 2^5 = 32 bits.
- `CLUSTER_INPUT_WIDTH`, 5: external fabric inputs.
- `io_in[0]`  in  1  clock `clk`. One clock; reset is synchronous and active-high.
- `io_in[1]`  in  1  `rst` when `io_in[2]`=0 (synchronous, active-high); `prog_in` serial config data when `io_in[2]`=1.
- `io_in[2]`  in  1  `prog_en`: 1 = programming mode.
- `io_in[7:3]`  in  5  fabric inputs `fin[4:0]`.
- `io_out[3:0]`  out  4  BEL outputs `bel_out[3:0]`.
- `io_out[6]`  out  1  `prog_out`, scan chain tail.
- `io_out[5:4]`, `io_out[7]`  out  constant 0.

## Operation
- Config chain: 4 x 53 = 212 bits, `cfg[211:0]`; BEL k owns `cfg[53k+52:53k]`.
- Per-BEL layout (local bit): [31:0] LUT truth table, index = {in4,in3,in2,in1,in0}; [32] `ff_en`; [33+4i+3:33+4i] `sel_i` for LUT input i (i=0..4).
- Select encoding: 0-4 -> `fin[sel]`; 5-8 -> `bel_out[sel-5]`; 9-15 -> constant 0.
- BEL: `lut = table[index]`; `bel_out = ff_en ? q : lut`; `q` <= `lut` each clock.
- Programming (`prog_en`=1): each rising clk, `cfg <= {cfg[210:0], prog_in}`; `prog_out = cfg[211]` (combinational from register). Stream is sent highest bit first: after 212 clocks the first bit sent sits in `cfg[211]`.
- While `prog_en`=1: all BEL FFs forced to 0 synchronously, `io_out[3:0]` forced 0. Config unchanged when `prog_en`=0.
- `rst` (only with `prog_en`=0): clears all BEL FFs to 0; config is NOT reset and is retained.
- Combinational feedback loops (unregistered BEL selecting itself or another unregistered BEL in a cycle) are legal to configure but undefined; user's responsibility.
- Unprogrammed config after power-up is undefined; use requires a full 212-bit load.

## Timing
- Reset values: BEL FFs 0; `io_out[3:0]` = 0 only if registered BELs (unregistered outputs follow inputs); `prog_out` = `cfg[211]` (config not reset); unused outputs 0.
- Unregistered BEL: zero-cycle input-to-output.
- Registered BEL: output updates on rising edge following input change (1-cycle latency).
- Chain: bit entering at edge n appears on `prog_out` after edge n+211 (212-cycle pass-through).
- `prog_en` sampled each edge; toggling mid-load is allowed, chain simply pauses; shifted bits persist.
- `rst` and `prog_en` simultaneous cannot occur (shared pin); in prog mode pin 1 is data only.

## Structure
- Package `tinyfpga_pkg`: `BELS`, `BEL_INPUT_WIDTH`, `CLUSTER_INPUT_WIDTH`, `LUT_BITS`=32, `SEL_W`=4, `BEL_CFG_BITS`=53, `CFG_BITS`=212, select encoding constants (`SEL_FIN0`=0, `SEL_BEL0`=5, `SEL_ZERO`=15).
- Sub-module `tinyfpga_bel`: 53-bit config slice in, 9 source signals in, clk/rst/prog_en in, output out; top holds the shift register and pin mapping.

## Test plan
- Chain passthrough: prog_en=1, shift 212 bits of pattern P, then 212 zeros -> `prog_out` replays P bit-for-bit in send order starting at the 213th clock.
- AND gate: BEL0 table=0x00000008, ff_en=0, sel0=0, sel1=1, sel2..4=15; prog_en=0; `fin`=5'b00011 -> `io_out[0]`=1; `fin`=5'b00001 -> 0.
- Toggle: BEL1 table=0x00000001, ff_en=1, sel0=6, others 15; rst 1 clock -> `io_out[1]`=0, then 0,1,0,1 on successive edges.
- Reset mid-run: during toggle assert rst one clock -> `io_out[1]`=0 next edge; release -> toggling resumes from 0, config intact.
- Cross-BEL: BEL2 = buffer of BEL1 (table=0x2, sel0=6, ff_en=0), BEL1 toggling -> `io_out[2]` equals `io_out[1]` same cycle.
- Prog mode entry: toggling design, set prog_en=1 -> `io_out[3:0]`=0 while asserted; `io_out[5:4]`,`io_out[7]` always 0.
